pwm_generator: RTL and testbench

PWM_GENERATOR -- requirements
Module: pwm_generator

---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_generator_if.sv | 27 ++
 rtl/pwm_generator_tick_sync.sv | 39 +++
 rtl/pwm_generator.sv | 132 +++++++++++++
 tb/tb_pwm_generator.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator: default widths and the FSM state encoding.
package pwm_pkg;

   localparam int CNT_W_DEFAULT       = 16;
   localparam int SYNC_STAGES_DEFAULT = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } pwm_state_t;

   // RUN and DRAIN both keep the period counter alive.
   function automatic logic is_active(input pwm_state_t s);
      return (s == ST_RUN) || (s == ST_DRAIN);
   endfunction

endpackage

// File: rtl/pwm_generator_if.sv
// Control, configuration handshake and status signals of the PWM generator.
interface pwm_generator_if
   import pwm_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
);

   logic             en;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [CNT_W-1:0] cfg_period;
   logic [CNT_W-1:0] cfg_duty;
   logic             pwm_out;
   logic             period_done;
   logic             busy;

   modport master (
      output en, cfg_valid, cfg_period, cfg_duty,
      input  cfg_ready, pwm_out, period_done, busy
   );

   modport slave (
      input  en, cfg_valid, cfg_period, cfg_duty,
      output cfg_ready, pwm_out, period_done, busy
   );

endinterface

// File: rtl/pwm_generator_tick_sync.sv
// Synchronizes the divided tick_clk into the clk_in domain and emits one pulse per rising edge.
module tick_sync
   import pwm_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic clk_in,
   input  logic rst,
   input  logic async_in,
   output logic tick
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES:0]   fill_q;
   logic                   prev_q;

   // fill_q marks which stages hold real samples, so a level that is already
   // high when reset is released never looks like a fresh rising edge.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         fill_q <= '0;
         prev_q <= 1'b0;
         tick   <= 1'b0;
      end else begin
         sync_q[0] <= async_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         fill_q[0] <= 1'b1;
         for (int i = 1; i <= SYNC_STAGES; i++) begin
            fill_q[i] <= fill_q[i-1];
         end
         prev_q <= sync_q[SYNC_STAGES-1];
         tick   <= fill_q[SYNC_STAGES] & sync_q[SYNC_STAGES-1] & ~prev_q;
      end
   end

endmodule

// File: rtl/pwm_generator.sv
// Tick-driven PWM generator with IDLE/RUN/DRAIN control and shadowed configuration
// that only takes effect on a period boundary.
module pwm_generator
   import pwm_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEFAULT,
   parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             tick_clk,
   input  logic             en,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [CNT_W-1:0] cfg_duty,
   output logic             pwm_out,
   output logic             period_done,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   pwm_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] act_period_q, act_duty_q;
   logic [CNT_W-1:0] sh_period_q, sh_duty_q;
   logic             pending_q;
   logic             tick;
   logic             running;
   logic             accept;
   logic             wrap;
   logic [CNT_W-1:0] period_after_wrap;

   tick_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_tick_sync (
      .clk_in  (clk_in),
      .rst     (rst),
      .async_in(tick_clk),
      .tick    (tick)
   );

   assign running           = is_active(state_q);
   assign accept            = cfg_valid && cfg_ready;
   assign wrap              = tick && running && (cnt_q == (act_period_q - CNT_ONE));
   assign period_after_wrap = pending_q ? sh_period_q : act_period_q;
   assign cfg_ready         = !pending_q;
   assign busy              = running;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (tick && running) begin
         cnt_d = wrap ? '0 : cnt_q + CNT_ONE;
      end
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (en && (act_period_q != '0)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // A shadowed zero period cannot be counted, so it parks the FSM.
            if (wrap && (period_after_wrap == '0)) begin
               state_d = ST_IDLE;
            end else if (!en) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (wrap && (!en || (period_after_wrap == '0))) begin
               state_d = ST_IDLE;
            end else if (en) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A handshake needs pending clear, so it can never collide with the shadow copy.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         act_period_q <= '0;
         act_duty_q   <= '0;
         sh_period_q  <= '0;
         sh_duty_q    <= '0;
         pending_q    <= 1'b0;
      end else begin
         if (accept) begin
            if (running) begin
               sh_period_q <= cfg_period;
               sh_duty_q   <= cfg_duty;
               pending_q   <= 1'b1;
            end else begin
               act_period_q <= cfg_period;
               act_duty_q   <= cfg_duty;
            end
         end else if (wrap && pending_q) begin
            act_period_q <= sh_period_q;
            act_duty_q   <= sh_duty_q;
            pending_q    <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         pwm_out     <= 1'b0;
         period_done <= 1'b0;
      end else begin
         pwm_out     <= running && (cnt_q < act_duty_q);
         period_done <= wrap;
      end
   end

endmodule

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator against a tick-level behavioural model.
module tb_pwm_generator;
   import pwm_pkg::*;

   localparam int CNT_W = 16;
   localparam int SLOW  = 150;
   localparam int FAST  = 10;

   logic clk_in = 1'b0;
   logic rst;
   logic tick_clk;

   pwm_generator_if #(.CNT_W(CNT_W)) bus ();

   pwm_generator #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(2)
   ) dut (
      .clk_in     (clk_in),
      .rst        (rst),
      .tick_clk   (tick_clk),
      .en         (bus.en),
      .cfg_valid  (bus.cfg_valid),
      .cfg_ready  (bus.cfg_ready),
      .cfg_period (bus.cfg_period),
      .cfg_duty   (bus.cfg_duty),
      .pwm_out    (bus.pwm_out),
      .period_done(bus.period_done),
      .busy       (bus.busy)
   );

   always #5 clk_in = ~clk_in;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   pd_count = 0;
   int   pd_long  = 0;
   logic pd_prev  = 1'b0;

   always @(posedge clk_in) begin
      if (bus.period_done === 1'b1) begin
         pd_count <= pd_count + 1;
         if (pd_prev) pd_long <= pd_long + 1;
      end
      pd_prev <= (bus.period_done === 1'b1);
   end

   // Model: position inside the current period, counted in ticks.
   int m_P, m_D, m_sP, m_sD, m_pos;
   bit m_busy, m_en, m_pend;

   logic s_pwm, s_busy, s_rdy, e_pwm;
   int   s_pd, e_pd;

   task automatic model_reset();
      m_P = 0; m_D = 0; m_sP = 0; m_sD = 0; m_pos = 0;
      m_busy = 0; m_en = 0; m_pend = 0;
   endtask

   task automatic model_en(input bit e);
      m_en = e;
      if (e && !m_busy && m_P != 0) begin m_busy = 1; m_pos = 0; end
   endtask

   task automatic model_cfg(input int p, input int d);
      if (!m_pend) begin
         if (m_busy) begin
            m_sP = p; m_sD = d; m_pend = 1;
         end else begin
            m_P = p; m_D = d;
            if (m_en && m_P != 0) begin m_busy = 1; m_pos = 0; end
         end
      end
   endtask

   task automatic model_tick(output int pd);
      pd = 0;
      if (m_busy) begin
         m_pos++;
         if (m_pos == m_P) begin
            m_pos = 0;
            pd = 1;
            if (m_pend) begin m_P = m_sP; m_D = m_sD; m_pend = 0; end
            if (!m_en || m_P == 0) m_busy = 0;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.en = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_period = '0; bus.cfg_duty = '0;
      tick_clk = 1'b0;
      repeat (3) @(negedge clk_in);
      rst = 1'b0;
      model_reset();
      repeat (2) @(negedge clk_in);
   endtask

   task automatic send_cfg(input int p, input int d);
      @(negedge clk_in);
      bus.cfg_valid = 1'b1; bus.cfg_period = CNT_W'(p); bus.cfg_duty = CNT_W'(d);
      @(negedge clk_in);
      bus.cfg_valid = 1'b0;
      model_cfg(p, d);
   endtask

   task automatic set_en(input bit e);
      @(negedge clk_in);
      bus.en = e;
      model_en(e);
   endtask

   task automatic do_tick(input int half, output logic pwm_s, output int pd_s,
                          output logic busy_s, output logic rdy_s);
      int pd0;
      pd0 = pd_count;
      @(negedge clk_in);
      tick_clk = 1'b1;
      repeat (half) @(negedge clk_in);
      pwm_s = bus.pwm_out; busy_s = bus.busy; rdy_s = bus.cfg_ready;
      tick_clk = 1'b0;
      repeat (half) @(negedge clk_in);
      pd_s = pd_count - pd0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.en = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_period = '0; bus.cfg_duty = '0;
      tick_clk = 1'b0;
      #1;
      n_checks += 4;
      if (bus.pwm_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pwm: got %b want 0", bus.pwm_out); end
      if (bus.period_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pd: got %b want 0", bus.period_done); end
      if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
      if (bus.cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b want 1", bus.cfg_ready); end
      do_reset();
      n_checks += 2;
      if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_busy: got %b want 0", bus.busy); end
      if (bus.cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_ready: got %b want 1", bus.cfg_ready); end
   endtask

   task automatic test_basic();
      do_reset();
      send_cfg(10, 3);
      set_en(1'b1);
      for (int k = 1; k <= 20; k++) begin
         model_tick(e_pd); e_pwm = m_busy && (m_pos < m_D);
         do_tick(SLOW, s_pwm, s_pd, s_busy, s_rdy);
         n_checks += 2;
         if (s_pwm !== e_pwm) begin n_fail++; $display("[TB] FAIL basic_pwm tick %0d: got %b want %b", k, s_pwm, e_pwm); end
         if (s_pd !== e_pd) begin n_fail++; $display("[TB] FAIL basic_pd tick %0d: got %0d want %0d", k, s_pd, e_pd); end
      end
   endtask

   task automatic test_duty_extremes();
      do_reset();
      send_cfg(10, 0);
      set_en(1'b1);
      for (int k = 1; k <= 32; k++) begin
         if (k == 12) send_cfg(10, 12);
         model_tick(e_pd); e_pwm = m_busy && (m_pos < m_D);
         do_tick(FAST, s_pwm, s_pd, s_busy, s_rdy);
         n_checks += 2;
         if (s_pwm !== e_pwm) begin n_fail++; $display("[TB] FAIL extreme_pwm tick %0d: got %b want %b", k, s_pwm, e_pwm); end
         if (s_pd !== e_pd) begin n_fail++; $display("[TB] FAIL extreme_pd tick %0d: got %0d want %0d", k, s_pd, e_pd); end
      end
   endtask

   task automatic test_reconfig();
      do_reset();
      send_cfg(10, 3);
      set_en(1'b1);
      for (int k = 1; k <= 22; k++) begin
         if (k == 3) begin
            send_cfg(10, 5);
            n_checks++;
            if (bus.cfg_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reconfig_ready_drop: got %b want 0", bus.cfg_ready); end
         end
         model_tick(e_pd); e_pwm = m_busy && (m_pos < m_D);
         do_tick(FAST, s_pwm, s_pd, s_busy, s_rdy);
         n_checks += 3;
         if (s_pwm !== e_pwm) begin n_fail++; $display("[TB] FAIL reconfig_pwm tick %0d: got %b want %b", k, s_pwm, e_pwm); end
         if (s_pd !== e_pd) begin n_fail++; $display("[TB] FAIL reconfig_pd tick %0d: got %0d want %0d", k, s_pd, e_pd); end
         if (s_rdy !== !m_pend) begin n_fail++; $display("[TB] FAIL reconfig_ready tick %0d: got %b want %b", k, s_rdy, !m_pend); end
      end
   endtask

   task automatic test_drain();
      do_reset();
      send_cfg(10, 3);
      set_en(1'b1);
      for (int k = 1; k <= 31; k++) begin
         if (k == 5) begin
            set_en(1'b0);
            n_checks++;
            if (bus.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_busy_hold: got %b want 1", bus.busy); end
         end
         if (k == 12) set_en(1'b1);
         if (k == 15) set_en(1'b0);
         if (k == 17) set_en(1'b1);
         model_tick(e_pd); e_pwm = m_busy && (m_pos < m_D);
         do_tick(FAST, s_pwm, s_pd, s_busy, s_rdy);
         n_checks += 3;
         if (s_pwm !== e_pwm) begin n_fail++; $display("[TB] FAIL drain_pwm tick %0d: got %b want %b", k, s_pwm, e_pwm); end
         if (s_pd !== e_pd) begin n_fail++; $display("[TB] FAIL drain_pd tick %0d: got %0d want %0d", k, s_pd, e_pd); end
         if (s_busy !== m_busy) begin n_fail++; $display("[TB] FAIL drain_busy tick %0d: got %b want %b", k, s_busy, m_busy); end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      send_cfg(10, 8);
      set_en(1'b1);
      for (int k = 1; k <= 6; k++) begin
         if (k == 6) send_cfg(10, 2);
         model_tick(e_pd); e_pwm = m_busy && (m_pos < m_D);
         do_tick(FAST, s_pwm, s_pd, s_busy, s_rdy);
         n_checks++;
         if (s_pwm !== e_pwm) begin n_fail++; $display("[TB] FAIL rstmid_pwm tick %0d: got %b want %b", k, s_pwm, e_pwm); end
      end
      n_checks++;
      if (bus.cfg_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_pending: got %b want 0", bus.cfg_ready); end
      #2 rst = 1'b1;
      tick_clk = 1'b1;
      #1;
      n_checks += 4;
      if (bus.pwm_out !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_async_pwm: got %b want 0", bus.pwm_out); end
      if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_async_busy: got %b want 0", bus.busy); end
      if (bus.period_done !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_async_pd: got %b want 0", bus.period_done); end
      if (bus.cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_async_ready: got %b want 1", bus.cfg_ready); end
      bus.en = 1'b0;
      repeat (2) @(negedge clk_in);
      rst = 1'b0;
      model_reset();
      @(negedge clk_in);
      n_checks++;
      if (bus.cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_release_ready: got %b want 1", bus.cfg_ready); end
      bus.cfg_valid = 1'b1; bus.cfg_period = CNT_W'(2); bus.cfg_duty = CNT_W'(1); bus.en = 1'b1;
      @(negedge clk_in);
      bus.cfg_valid = 1'b0;
      model_cfg(2, 1);
      model_en(1'b1);
      repeat (20) @(negedge clk_in);
      e_pwm = m_busy && (m_pos < m_D);
      n_checks += 2;
      if (bus.pwm_out !== e_pwm) begin n_fail++; $display("[TB] FAIL high_release_pwm: got %b want %b", bus.pwm_out, e_pwm); end
      if (bus.busy !== m_busy) begin n_fail++; $display("[TB] FAIL high_release_busy: got %b want %b", bus.busy, m_busy); end
      tick_clk = 1'b0;
      repeat (FAST) @(negedge clk_in);
      for (int k = 1; k <= 5; k++) begin
         model_tick(e_pd); e_pwm = m_busy && (m_pos < m_D);
         do_tick(FAST, s_pwm, s_pd, s_busy, s_rdy);
         n_checks += 2;
         if (s_pwm !== e_pwm) begin n_fail++; $display("[TB] FAIL high_release_pwm tick %0d: got %b want %b", k, s_pwm, e_pwm); end
         if (s_pd !== e_pd) begin n_fail++; $display("[TB] FAIL high_release_pd tick %0d: got %0d want %0d", k, s_pd, e_pd); end
      end
   endtask

   task automatic test_period_zero();
      do_reset();
      send_cfg(0, 5);
      set_en(1'b1);
      for (int k = 1; k <= 12; k++) begin
         model_tick(e_pd); e_pwm = m_busy && (m_pos < m_D);
         do_tick(FAST, s_pwm, s_pd, s_busy, s_rdy);
         n_checks += 3;
         if (s_pwm !== e_pwm) begin n_fail++; $display("[TB] FAIL zero_pwm tick %0d: got %b want %b", k, s_pwm, e_pwm); end
         if (s_pd !== e_pd) begin n_fail++; $display("[TB] FAIL zero_pd tick %0d: got %0d want %0d", k, s_pd, e_pd); end
         if (s_busy !== m_busy) begin n_fail++; $display("[TB] FAIL zero_busy tick %0d: got %b want %b", k, s_busy, m_busy); end
      end
   endtask

   task automatic test_random();
      int p, d, p2, d2, r, n;
      for (int it = 0; it < 4; it++) begin
         do_reset();
         p  = $urandom_range(12, 2);
         d  = $urandom_range(p + 2, 0);
         p2 = $urandom_range(12, 1);
         d2 = $urandom_range(p2 + 2, 0);
         r  = $urandom_range(p - 1, 1);
         n  = p + 2 * p2;
         send_cfg(p, d);
         set_en(1'b1);
         for (int k = 1; k <= n; k++) begin
            if (k == r + 1) send_cfg(p2, d2);
            model_tick(e_pd); e_pwm = m_busy && (m_pos < m_D);
            do_tick(FAST, s_pwm, s_pd, s_busy, s_rdy);
            n_checks += 3;
            if (s_pwm !== e_pwm) begin n_fail++; $display("[TB] FAIL rand%0d_pwm tick %0d (p=%0d d=%0d p2=%0d d2=%0d): got %b want %b", it, k, p, d, p2, d2, s_pwm, e_pwm); end
            if (s_pd !== e_pd) begin n_fail++; $display("[TB] FAIL rand%0d_pd tick %0d: got %0d want %0d", it, k, s_pd, e_pd); end
            if (s_rdy !== !m_pend) begin n_fail++; $display("[TB] FAIL rand%0d_ready tick %0d: got %b want %b", it, k, s_rdy, !m_pend); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_duty_extremes();
      test_reconfig();
      test_drain();
      test_reset_mid();
      test_period_zero();
      test_random();
      n_checks++;
      if (pd_long !== 0) begin n_fail++; $display("[TB] FAIL pd_width: %0d over-long pulses, want 0", pd_long); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
